// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester, hazard-check and register-file write-port bundle
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]         chk_addr_a;
  logic [ADDR_W-1:0]         chk_addr_b;
  logic                      hazard_a;
  logic                      hazard_b;
  logic [(1<<ADDR_W)-1:0]    busy_mask;
  logic                      w_en;
  logic [ADDR_W-1:0]         addr_c;
  logic [DATA_W-1:0]         data_c;

  modport master (
    output req_valid, req_addr, req_data, chk_addr_a, chk_addr_b,
    input  req_ready, hazard_a, hazard_b, busy_mask, w_en, addr_c, data_c
  );

  modport slave (
    input  req_valid, req_addr, req_data, chk_addr_a, chk_addr_b,
    output req_ready, hazard_a, hazard_b, busy_mask, w_en, addr_c, data_c
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard
// Optional WB_R0_LOCK_EN: register 0 hard-wired, writes to it are accepted and dropped.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [NUM_REQ-1:0] hold_valid;
  logic [ADDR_W-1:0]  hold_addr [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [PTR_W-1:0]   ptr;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gidx;
  logic               any_grant;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] load_ok;
  logic [PTR_W-1:0]   idx;
  logic [NREG-1:0]    busy;

  // Rotating priority search: first valid slot at or after ptr wins.
  always_comb begin
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(ptr) + k >= NUM_REQ)
        idx = PTR_W'(int'(ptr) + k - NUM_REQ);
      else
        idx = PTR_W'(int'(ptr) + k);
      if (!any_grant && hold_valid[idx]) begin
        any_grant = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = !hold_valid[i] || grant[i];
      accept[i]        = bus.req_valid[i] && bus.req_ready[i];
`ifdef WB_R0_LOCK_EN
      load_ok[i] = (bus.req_addr[i*ADDR_W +: ADDR_W] != '0);
`else
      load_ok[i] = 1'b1;
`endif
    end
  end

  // A slot granted and re-accepted in the same cycle reloads, giving 1/cycle throughput.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_addr[i] <= '0;
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i] && load_ok[i]) begin
          hold_valid[i] <= 1'b1;
          hold_addr[i]  <= bus.req_addr[i*ADDR_W +: ADDR_W];
          hold_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any_grant) begin
      if (int'(gidx) == NUM_REQ - 1)
        ptr <= '0;
      else
        ptr <= gidx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.w_en   <= 1'b0;
      bus.addr_c <= '0;
      bus.data_c <= '0;
    end else if (any_grant) begin
      bus.w_en   <= 1'b1;
      bus.addr_c <= hold_addr[gidx];
      bus.data_c <= hold_data[gidx];
    end else begin
      bus.w_en   <= 1'b0;
    end
  end

  // A register stays busy until the cycle its w_en pulse completes.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (hold_valid[i]) busy[hold_addr[i]] = 1'b1;
    if (bus.w_en) busy[bus.addr_c] = 1'b1;
`ifdef WB_R0_LOCK_EN
    busy[0] = 1'b0;
`endif
  end

  assign bus.busy_mask = busy;
  assign bus.hazard_a  = busy[bus.chk_addr_a];
  assign bus.hazard_b  = busy[bus.chk_addr_b];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(4)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          r;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [3:0]  ca;
    logic [3:0]  cb;
    logic [15:0] exp_busy;
    logic        exp_ha;
    logic        exp_hb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int r, input logic v, input logic [3:0] a, input logic [15:0] d);
    bus.req_valid[r]        = v;
    bus.req_addr[r*4 +: 4]  = a;
    bus.req_data[r*16 +: 16] = d;
  endtask

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] exp_d;
  int acc_r[2];
  int acc_cnt, pulse_cnt, last_who, who, pulses;

  initial begin
    vecs[0] = '{0, 4'd5,  16'hBEEF, 4'd5,  4'd8,  16'h0020, 1'b1, 1'b0};
    vecs[1] = '{1, 4'd7,  16'h1357, 4'd7,  4'd8,  16'h0080, 1'b1, 1'b0};
    vecs[2] = '{2, 4'd15, 16'hA5A5, 4'd0,  4'd15, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{0, 4'd8,  16'h0F0F, 4'd8,  4'd8,  16'h0100, 1'b1, 1'b1};
    vecs[4] = '{1, 4'd3,  16'hFFFF, 4'd2,  4'd4,  16'h0008, 1'b0, 1'b0};
    vecs[5] = '{2, 4'd12, 16'h0001, 4'd12, 4'd11, 16'h1000, 1'b1, 1'b0};

    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.chk_addr_a = '0;
    bus.chk_addr_b = '0;

    #3;
    chk("rst_w_en", 32'(bus.w_en), 32'd0);
    chk("rst_addr_c", 32'(bus.addr_c), 32'd0);
    chk("rst_data_c", 32'(bus.data_c), 32'd0);
    chk("rst_busy", 32'(bus.busy_mask), 32'h0000);
    chk("rst_ready", 32'(bus.req_ready), 32'b111);
    chk("rst_haz", 32'({bus.hazard_a, bus.hazard_b}), 32'd0);
    tick;
    rst = 1'b1;
    tick;

    // Single-request vectors: accept, busy, pulse, clear.
    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].r, 1'b1, vecs[v].addr, vecs[v].data);
      bus.chk_addr_a = vecs[v].ca;
      bus.chk_addr_b = vecs[v].cb;
      #1;
      chk($sformatf("v%0d_ready", v), 32'(bus.req_ready[vecs[v].r]), 32'd1);
      tick;
      drive(vecs[v].r, 1'b0, 4'd0, 16'd0);
      #1;
      chk($sformatf("v%0d_busy_held", v), 32'(bus.busy_mask), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_ha", v), 32'(bus.hazard_a), 32'(vecs[v].exp_ha));
      chk($sformatf("v%0d_hb", v), 32'(bus.hazard_b), 32'(vecs[v].exp_hb));
      chk($sformatf("v%0d_wen0", v), 32'(bus.w_en), 32'd0);
      tick;
      chk($sformatf("v%0d_wen1", v), 32'(bus.w_en), 32'd1);
      chk($sformatf("v%0d_addr_c", v), 32'(bus.addr_c), 32'(vecs[v].addr));
      chk($sformatf("v%0d_data_c", v), 32'(bus.data_c), 32'(vecs[v].data));
      chk($sformatf("v%0d_busy_wen", v), 32'(bus.busy_mask), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_ha_wen", v), 32'(bus.hazard_a), 32'(vecs[v].exp_ha));
      tick;
      chk($sformatf("v%0d_wen_drop", v), 32'(bus.w_en), 32'd0);
      chk($sformatf("v%0d_busy_clr", v), 32'(bus.busy_mask), 32'h0000);
      chk($sformatf("v%0d_haz_clr", v), 32'({bus.hazard_a, bus.hazard_b}), 32'd0);
      chk($sformatf("v%0d_data_hold", v), 32'(bus.data_c), 32'(vecs[v].data));
    end

    // Mid-stream reset with slots 0 and 2 full.
    drive(0, 1'b1, 4'd9, 16'h9999);
    drive(2, 1'b1, 4'd10, 16'hAAAA);
    tick;
    drive(0, 1'b0, 4'd0, 16'd0);
    drive(2, 1'b0, 4'd0, 16'd0);
    #1;
    chk("mid_busy_before", 32'(bus.busy_mask), 32'h0600);
    rst = 1'b0;
    #1;
    chk("mid_rst_w_en", 32'(bus.w_en), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_mask), 32'h0000);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'b111);
    tick;
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (bus.w_en) pulses++;
    end
    chk("mid_rst_no_replay", 32'(pulses), 32'd0);

    // Round robin from ptr=0: all three at once.
    drive(0, 1'b1, 4'd1, 16'h1111);
    drive(1, 1'b1, 4'd2, 16'h2222);
    drive(2, 1'b1, 4'd3, 16'h3333);
    tick;
    for (int r = 0; r < 3; r++) drive(r, 1'b0, 4'd0, 16'd0);
    #1;
    chk("rr_busy", 32'(bus.busy_mask), 32'h000E);
    tick;
    chk("rr_p1", 32'({bus.w_en, bus.addr_c, bus.data_c}), {11'd0, 1'b1, 4'd1, 16'h1111});
    tick;
    chk("rr_p2", 32'({bus.w_en, bus.addr_c, bus.data_c}), {11'd0, 1'b1, 4'd2, 16'h2222});
    tick;
    chk("rr_p3", 32'({bus.w_en, bus.addr_c, bus.data_c}), {11'd0, 1'b1, 4'd3, 16'h3333});
    tick;
    chk("rr_idle", 32'(bus.w_en), 32'd0);
    // With ptr back at 0, requester 1 and 0 together: 0 wins first.
    drive(1, 1'b1, 4'd6, 16'h6666);
    drive(0, 1'b1, 4'd4, 16'h4444);
    tick;
    drive(0, 1'b0, 4'd0, 16'd0);
    drive(1, 1'b0, 4'd0, 16'd0);
    tick;
    chk("rr_ptr0_first", 32'(bus.addr_c), 32'd4);
    tick;
    chk("rr_ptr0_second", 32'(bus.addr_c), 32'd6);
    tick;

    // Contention: requesters 0 and 1 stream 10 each.
    acc_r[0] = 0; acc_r[1] = 0;
    acc_cnt = 0; pulse_cnt = 0; last_who = -1;
    for (int c = 0; c < 80 && pulse_cnt < 20; c++) begin
      for (int r = 0; r < 2; r++)
        drive(r, acc_r[r] < 10, 4'(r + 1), 16'(16'h1000 * (r + 1) + acc_r[r]));
      #1;
      for (int r = 0; r < 2; r++) begin
        if (bus.req_valid[r] && bus.req_ready[r]) begin
          if (r == 0) q0.push_back(bus.req_data[15:0]);
          else        q1.push_back(bus.req_data[31:16]);
          acc_r[r]++;
          acc_cnt++;
        end
      end
      tick;
      if (bus.w_en) begin
        pulse_cnt++;
        who = int'(bus.data_c[15:12]) - 1;
        if (who == 0 && q0.size() > 0)      exp_d = q0.pop_front();
        else if (who == 1 && q1.size() > 0) exp_d = q1.pop_front();
        else exp_d = 16'hXXXX;
        chk("stream_data", 32'(bus.data_c), 32'(exp_d));
        chk("stream_addr", 32'(bus.addr_c), 32'(who + 1));
        if (last_who >= 0) chk("stream_alt", 32'(who), 32'(1 - last_who));
        last_who = who;
      end
    end
    for (int r = 0; r < 2; r++) drive(r, 1'b0, 4'd0, 16'd0);
    chk("stream_accepts", 32'(acc_cnt), 32'd20);
    chk("stream_pulses", 32'(pulse_cnt), 32'd20);
    tick;
    tick;
    chk("stream_drained", 32'({bus.w_en, bus.busy_mask}), 32'd0);

    // Register 0 write.
    drive(0, 1'b1, 4'd0, 16'h1234);
    bus.chk_addr_a = 4'd0;
    #1;
    chk("r0_ready", 32'(bus.req_ready[0]), 32'd1);
    tick;
    drive(0, 1'b0, 4'd0, 16'd0);
    #1;
`ifdef WB_R0_LOCK_EN
    chk("r0_busy", 32'(bus.busy_mask), 32'h0000);
    chk("r0_haz", 32'(bus.hazard_a), 32'd0);
    tick;
    chk("r0_no_wen", 32'(bus.w_en), 32'd0);
    chk("r0_busy_wen", 32'(bus.busy_mask), 32'h0000);
`else
    chk("r0_busy", 32'(bus.busy_mask), 32'h0001);
    chk("r0_haz", 32'(bus.hazard_a), 32'd1);
    tick;
    chk("r0_wen", 32'({bus.w_en, bus.addr_c, bus.data_c}), {11'd0, 1'b1, 4'd0, 16'h1234});
`endif
    tick;
    chk("r0_end", 32'(bus.w_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port arbiter for the 16x16 register file. The register file has a single write port (w_en/addr_c/data_c), and several writeback sources share it.
- Each requester gets a one-entry holding slot and a valid/ready handshake.
- A round-robin grant picks one slot per cycle and drives a registered write port.
- A 16-bit pending-write scoreboard and read-hazard flags are produced for the issue stage.

Parameters:
NUM_REQ, 3, number of writeback requesters (legal 2..4)
DATA_W, 16, register data width
ADDR_W, 4, register address width (16 registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a write pending
req_ready  out  NUM_REQ  slot i can accept this cycle
req_addr  in  NUM_REQ*ADDR_W  destination register, requester i at bits [i*4 +: 4]
req_data  in  NUM_REQ*DATA_W  write data, requester i at bits [i*16 +: 16]
chk_addr_a  in  ADDR_W  issue-stage source register A
chk_addr_b  in  ADDR_W  issue-stage source register B
hazard_a  out  1  chk_addr_a has a pending write
hazard_b  out  1  chk_addr_b has a pending write
busy_mask  out  16  bit k set = register k has a pending write
w_en  out  1  register-file write enable (registered)
addr_c  out  ADDR_W  register-file write address (registered)
data_c  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (rst=0, async):
  - all slots invalid; rr pointer=0.
  - w_en=0, addr_c=0, data_c=0.
  - busy_mask=0, hazard_a/b=0.
  - Pending writes are discarded; there is no replay after reset.
- Slot i: hold_valid, hold_addr, hold_data.
  - req_ready[i] = !hold_valid[i] | grant[i]. Combinational; never depends on req_valid.
  - Accept on req_valid[i] & req_ready[i]: slot loads at that edge.
  - Accept and grant of the same slot in one cycle: the slot is reloaded with the new request (back-to-back throughput 1/cycle per requester when uncontended).
- Arbitration, combinational each cycle:
  - Search hold_valid starting at index ptr, ascending with wrap; first valid slot gets a one-hot grant.
  - On grant to i: ptr <= (i+1) mod NUM_REQ.
  - No valid slot: no grant, ptr unchanged.
- Write port, registered:
  - On grant: w_en<=1, addr_c<=hold_addr[g], data_c<=hold_data[g].
  - Otherwise: w_en<=0; addr_c/data_c hold their previous values.
  - Exactly one w_en pulse per accepted request.
- Latency:
  - Accept at edge N; earliest grant in cycle N..N+1; w_en high in cycle N+1..N+2.
  - Register-file contents updated at the end of the w_en cycle.
  - Minimum accept-to-visible latency: 2 edges.
- Scoreboard: busy_mask = OR over valid slots of decode(hold_addr) | (w_en ? decode(addr_c) : 0).
  - hazard_a = busy_mask[chk_addr_a]; hazard_b = busy_mask[chk_addr_b]. Both combinational.
- Same-address writes:
  - From different requesters: committed in grant order (round-robin); the issuing logic must not depend on cross-requester ordering.
  - From one requester: committed in acceptance order.
- Starvation bound: a valid slot is granted within NUM_REQ cycles.
- Unknown/idle req lines are ignored when req_valid=0.

Optional Feature:
WB_R0_LOCK_EN
- Defined: register 0 is hard-wired.
  - Requests with addr=0 are handshaked normally (ready rules unchanged) but dropped.
  - The slot is not loaded, no w_en pulse occurs, and the busy bit 0 is never set.
  - hazard_a/b are always 0 for address 0.
- Undefined: register 0 behaves as any other register.

Test Plan:
1. Reset: rst=0 mid-stream with slots 0 and 2 full -> w_en=0, busy_mask=0x0000, req_ready all 1 immediately. No write occurs after rst=1.
2. Single write: req0 addr=5 data=0xBEEF at edge N -> w_en=1, addr_c=5, data_c=0xBEEF in cycle N+1. busy_mask=0x0020 from N until w_en drops.
3. Round-robin: all three valid at once (addr 1,2,3; data 0x1111/0x2222/0x3333), ptr=0 -> w_en pulses in order addr 1,2,3 on consecutive cycles. ptr ends at 0.
4. Contention/backpressure: req1 held valid continuously with new data each cycle while req0 also streams -> grants alternate 0,1,0,1. req_ready[1] is low only while slot 1 is full and not granted. No request is lost or duplicated (count 20 accepts = 20 pulses).
5. Hazard: slot holds addr=7, chk_addr_a=7, chk_addr_b=8 -> hazard_a=1, hazard_b=0. hazard_a clears the cycle after the w_en pulse for addr 7.
6. WB_R0_LOCK_EN defined: req0 addr=0 data=0x1234 accepted -> no w_en pulse, busy_mask bit 0 stays 0. Undefined: w_en pulse with addr_c=0, data_c=0x1234.
